alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle controller that drives the 8-bit ALU's control and operand inputs. It accepts one operation request at a time over a valid/ready handshake, loads the ALU's B register, runs the operation with the ALU output enabled, and captures the result and flags. The result is held for a downstream consumer under a second valid/ready handshake. It sits between the instruction control path and the ALU. It also tracks what the ALU B register holds, so the B-load cycle is skipped when the required B value is already loaded.

## Interface
Parameters: none (datapath fixed at 8 bits).

- i_clk  input  1  system clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  request can be accepted this cycle
- i_op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SHL, 101 SHR, 110 CMP, 111 NOT
- i_a  input  8  operand A
- i_b  input  8  operand B; for shifts, i_b[2:0] is the shift amount
- o_a  output  8  to ALU A input
- o_b  output  8  to ALU B load input
- o_bWr  output  1  ALU B-register write strobe
- o_oe  output  1  ALU output/flag enable
- o_subShiftDir  output  1  ALU subtract / shift-left select
- o_aluOp  output  2  ALU operation select
- i_y  input  8  ALU result bus
- o_resultValid  output  1  result available
- i_resultReady  input  1  consumer takes the result
- o_result  output  8  captured result
- o_negative  output  1  result[7]
- o_zero  output  1  result == 0
- o_writeback  output  1  0 for CMP, 1 otherwise

## Operation
- States are IDLE, LOAD_B, EXEC and DONE. o_ready = (state==IDLE) | (state==DONE & i_resultReady).
- A request is accepted on a rising edge with i_valid & o_ready. On acceptance the block latches i_op, i_a and the effective B value.
- Effective B is 8'hFF for NOT and i_b for every other op.
- Op mapping, given as {o_aluOp, o_subShiftDir}:
  - ADD = {00,0}; SUB = {00,1}; CMP = {00,1}
  - AND = {01,0}
  - XOR = {10,0}; NOT = {10,0} (XOR with 8'hFF)
  - SHL = {11,1}; SHR = {11,0}
- B cache: r_bCache (8 bits) and r_bCacheValid (1 bit), both cleared by reset.
  - On acceptance, if r_bCacheValid and effective B == r_bCache, the next state is EXEC. Otherwise the next state is LOAD_B.
- LOAD_B: o_b = effective B and o_bWr = 1. On the closing edge, r_bCache = effective B, r_bCacheValid = 1, and the next state is EXEC.
- EXEC: o_a = latched A, o_aluOp and o_subShiftDir per the mapping, o_oe = 1. On the closing edge the block captures o_result = i_y, o_negative = i_y[7], o_zero = (i_y == 0) and o_writeback = (op != CMP). The next state is DONE.
- DONE: o_resultValid = 1 and all result outputs are held stable until an edge with i_resultReady.
  - i_resultReady & i_valid on that edge: the new request is accepted back-to-back, going to LOAD_B or EXEC per the cache check.
  - i_resultReady without i_valid: return to IDLE.
- Outputs outside their own states:
  - o_bWr and o_oe are 0 outside LOAD_B and EXEC respectively.
  - o_a, o_b and o_aluOp are 0, and o_subShiftDir is 0, whenever not driven.
- Arithmetic wraps modulo 256; there is no carry output.
- Shift amounts 0–7 come from i_b[2:0]; bits i_b[7:3] do not affect the shift, but they do take part in the cache compare.

## Timing
- Reset (asynchronous, any state): state = IDLE. All outputs are 0 except o_ready = 1. Both cache registers are cleared. An operation in flight is discarded with no result.
- Cache miss: accept at edge N. LOAD_B runs from N to N+1, EXEC from N+1 to N+2, and o_resultValid is high from N+2.
- Cache hit: accept at edge N. EXEC runs from N to N+1, and o_resultValid is high from N+1.
- Sustained throughput is 3 cycles per op on a miss and 2 on a hit, given i_resultReady is held high.
- o_bWr and o_oe are single-cycle pulses and are never high in the same cycle.
- Request inputs are sampled only on the accepting edge. i_y is sampled only on the closing edge of EXEC.

## Test plan
- Reset, then ADD a=8'h7F, b=8'h01 against an ALU model: o_bWr pulses, then o_oe. o_result=8'h80, negative=1, zero=0, valid 2 edges after accept.
- SUB a=8'h05, b=8'h05 immediately after a B=8'h05 load: LOAD_B is skipped (no o_bWr). o_result=0, zero=1, resultValid 1 edge after accept.
- CMP a=8'h03, b=8'h07: o_result=8'hFC, negative=1, o_writeback=0. Then NOT a=8'h0F: B reloaded with 8'hFF, o_result=8'hF0.
- SHL a=8'h01, b=8'h03 gives 8'h08. SHR a=8'h80, b=8'h07 gives 8'h01. With b=8'h0B the shift amount is 3, and the op is a cache miss against b=8'h03.
- Hold i_resultReady=0 for 5 cycles in DONE: outputs are stable and o_ready=0. Raise it together with i_valid: the next op is accepted on the same edge.
- Assert i_reset mid-EXEC: outputs are immediately 0 and o_ready=1. The first op after reset takes the LOAD_B path.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle controller for the 8-bit ALU. It accepts one request at a time
//   over valid/ready, loads the ALU B register when needed, runs the op with
//   the ALU output enabled, captures result and flags, and holds them for a
//   downstream consumer under a second valid/ready handshake.
//
// Ports
//   i_clk, i_reset        clock (rising edge), async active-high reset
//   i_valid/o_ready       request handshake; i_op, i_a, i_b request payload
//   o_a, o_b, o_bWr       ALU A operand, B-register load value and strobe
//   o_oe, o_subShiftDir,
//   o_aluOp               ALU output enable and operation select
//   i_y                   ALU result bus
//   o_resultValid/
//   i_resultReady         result handshake
//   o_result, o_negative,
//   o_zero, o_writeback   captured result and flags
module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic       o_bWr,
  output logic       o_oe,
  output logic       o_subShiftDir,
  output logic [1:0] o_aluOp,
  input  logic [7:0] i_y,
  output logic       o_resultValid,
  input  logic       i_resultReady,
  output logic [7:0] o_result,
  output logic       o_negative,
  output logic       o_zero,
  output logic       o_writeback
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_B, S_EXEC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic [7:0] bcache_q;
  logic       bcache_vld_q;
  logic [7:0] res_q;
  logic       neg_q, zero_q, wb_q;

  logic       accept;
  logic [7:0] eff_b;
  logic       hit;

  // NOT is run as XOR against all-ones, so its B operand is forced to FF.
  assign eff_b  = (i_op == OP_NOT) ? 8'hFF : i_b;
  // Full 8-bit compare, including shift bits [7:3] that the ALU ignores.
  assign hit    = bcache_vld_q && (eff_b == bcache_q);
  assign accept = i_valid && o_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = hit ? S_EXEC : S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE: begin
        if (i_resultReady) begin
          if (accept) state_d = hit ? S_EXEC : S_LOAD_B;
          else        state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic; ALU controls are zero whenever their state is not active.
  always_comb begin
    o_ready       = (state_q == S_IDLE) || ((state_q == S_DONE) && i_resultReady);
    o_a           = 8'h00;
    o_b           = 8'h00;
    o_bWr         = 1'b0;
    o_oe          = 1'b0;
    o_aluOp       = 2'b00;
    o_subShiftDir = 1'b0;
    o_resultValid = (state_q == S_DONE);
    case (state_q)
      S_LOAD_B: begin
        o_b   = b_q;
        o_bWr = 1'b1;
      end
      S_EXEC: begin
        o_a  = a_q;
        o_oe = 1'b1;
        case (op_q)
          OP_ADD: begin o_aluOp = 2'b00; o_subShiftDir = 1'b0; end
          OP_SUB,
          OP_CMP: begin o_aluOp = 2'b00; o_subShiftDir = 1'b1; end
          OP_AND: begin o_aluOp = 2'b01; o_subShiftDir = 1'b0; end
          OP_XOR,
          OP_NOT: begin o_aluOp = 2'b10; o_subShiftDir = 1'b0; end
          OP_SHL: begin o_aluOp = 2'b11; o_subShiftDir = 1'b1; end
          OP_SHR: begin o_aluOp = 2'b11; o_subShiftDir = 1'b0; end
          default: begin o_aluOp = 2'b00; o_subShiftDir = 1'b0; end
        endcase
      end
      default: ;
    endcase
  end

  // Request latch, B cache and result capture
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q         <= 3'b000;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      bcache_q     <= 8'h00;
      bcache_vld_q <= 1'b0;
      res_q        <= 8'h00;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
      wb_q         <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= i_op;
        a_q  <= i_a;
        b_q  <= eff_b;
      end
      if (state_q == S_LOAD_B) begin
        bcache_q     <= b_q;
        bcache_vld_q <= 1'b1;
      end
      if (state_q == S_EXEC) begin
        res_q  <= i_y;
        neg_q  <= i_y[7];
        zero_q <= (i_y == 8'h00);
        wb_q   <= (op_q != OP_CMP);
      end
    end
  end

  assign o_result    = res_q;
  assign o_negative  = neg_q;
  assign o_zero      = zero_q;
  assign o_writeback = wb_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk, rst;
  logic       i_valid, o_ready;
  logic [2:0] i_op;
  logic [7:0] i_a, i_b;
  logic [7:0] o_a, o_b;
  logic       o_bWr, o_oe, o_subShiftDir;
  logic [1:0] o_aluOp;
  logic [7:0] i_y;
  logic       o_resultValid, i_resultReady;
  logic [7:0] o_result;
  logic       o_negative, o_zero, o_writeback;

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer dut (
    .i_clk(clk), .i_reset(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_a(o_a), .o_b(o_b), .o_bWr(o_bWr), .o_oe(o_oe),
    .o_subShiftDir(o_subShiftDir), .o_aluOp(o_aluOp),
    .i_y(i_y),
    .o_resultValid(o_resultValid), .i_resultReady(i_resultReady),
    .o_result(o_result), .o_negative(o_negative), .o_zero(o_zero),
    .o_writeback(o_writeback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: B register loaded by o_bWr, result bus driven only under o_oe.
  logic [7:0] alu_b;
  always @(posedge clk) if (o_bWr) alu_b <= o_b;
  always_comb begin
    i_y = 8'hA5;
    if (o_oe) begin
      case (o_aluOp)
        2'b00: i_y = o_subShiftDir ? (o_a - alu_b) : (o_a + alu_b);
        2'b01: i_y = o_a & alu_b;
        2'b10: i_y = o_a ^ alu_b;
        default: i_y = o_subShiftDir ? (o_a << alu_b[2:0]) : (o_a >> alu_b[2:0]);
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE. Presents the request
  // together with i_resultReady, then walks the pipeline one negedge at a time.
  // Leaves the DUT in DONE with i_resultReady low.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic exp_hit, input logic [7:0] exp_bval,
                       input logic [2:0] exp_ctl, input logic [7:0] exp_res,
                       input logic exp_neg, input logic exp_zero, input logic exp_wb);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_resultReady = 1'b1;
    #1;
    chk({tag, ".ready"}, {7'd0, o_ready}, 8'd1);
    @(negedge clk);
    i_valid = 1'b0; i_op = 3'b000; i_a = 8'h00; i_b = 8'h00; i_resultReady = 1'b0;
    if (!exp_hit) begin
      chk({tag, ".bWr"}, {7'd0, o_bWr}, 8'd1);
      chk({tag, ".b"}, o_b, exp_bval);
      chk({tag, ".oe_in_load"}, {7'd0, o_oe}, 8'd0);
      @(negedge clk);
    end
    chk({tag, ".oe"}, {7'd0, o_oe}, 8'd1);
    chk({tag, ".bWr_in_exec"}, {7'd0, o_bWr}, 8'd0);
    chk({tag, ".a"}, o_a, a);
    chk({tag, ".ctl"}, {5'd0, o_aluOp, o_subShiftDir}, {5'd0, exp_ctl});
    chk({tag, ".vld_early"}, {7'd0, o_resultValid}, 8'd0);
    @(negedge clk);
    chk({tag, ".vld"}, {7'd0, o_resultValid}, 8'd1);
    chk({tag, ".res"}, o_result, exp_res);
    chk({tag, ".flags"}, {5'd0, o_negative, o_zero, o_writeback},
        {5'd0, exp_neg, exp_zero, exp_wb});
    chk({tag, ".oe_off"}, {6'd0, o_oe, o_bWr}, 8'd0);
  endtask

  task automatic drain(input string tag);
    i_resultReady = 1'b1;
    @(negedge clk);
    i_resultReady = 1'b0;
    chk({tag, ".idle_vld"}, {7'd0, o_resultValid}, 8'd0);
    chk({tag, ".idle_rdy"}, {7'd0, o_ready}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_op = 3'b000; i_a = 8'h00; i_b = 8'h00;
    i_resultReady = 1'b0;
    #1;
    chk("rst.ready", {7'd0, o_ready}, 8'd1);
    chk("rst.ctl", {3'd0, o_bWr, o_oe, o_aluOp, o_subShiftDir}, 8'd0);
    chk("rst.ab", o_a | o_b, 8'h00);
    chk("rst.res", {o_result[6:0], o_resultValid} | {5'd0, o_negative, o_zero, o_writeback}, 8'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ctl = {aluOp, subShiftDir}
    do_op("add",  3'b000, 8'h7F, 8'h01, 1'b0, 8'h01, 3'b000, 8'h80, 1'b1, 1'b0, 1'b1);
    drain("add");
    do_op("add5", 3'b000, 8'h0A, 8'h05, 1'b0, 8'h05, 3'b000, 8'h0F, 1'b0, 1'b0, 1'b1);
    do_op("subh", 3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 3'b001, 8'h00, 1'b0, 1'b1, 1'b1);
    do_op("cmp",  3'b110, 8'h03, 8'h07, 1'b0, 8'h07, 3'b001, 8'hFC, 1'b1, 1'b0, 1'b0);
    do_op("not",  3'b111, 8'h0F, 8'h00, 1'b0, 8'hFF, 3'b100, 8'hF0, 1'b1, 1'b0, 1'b1);
    do_op("and",  3'b010, 8'h3C, 8'hFF, 1'b1, 8'h00, 3'b010, 8'h3C, 1'b0, 1'b0, 1'b1);
    do_op("xor",  3'b011, 8'hAA, 8'hFF, 1'b1, 8'h00, 3'b100, 8'h55, 1'b0, 1'b0, 1'b1);
    do_op("shl",  3'b100, 8'h01, 8'h03, 1'b0, 8'h03, 3'b111, 8'h08, 1'b0, 1'b0, 1'b1);
    do_op("shlB", 3'b100, 8'h01, 8'h0B, 1'b0, 8'h0B, 3'b111, 8'h08, 1'b0, 1'b0, 1'b1);
    do_op("shr",  3'b101, 8'h80, 8'h07, 1'b0, 8'h07, 3'b110, 8'h01, 1'b0, 1'b0, 1'b1);

    // Consumer stalls for 5 cycles; everything must hold.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold.vld", {7'd0, o_resultValid}, 8'd1);
      chk("hold.rdy", {7'd0, o_ready}, 8'd0);
      chk("hold.res", o_result, 8'h01);
      chk("hold.flags", {5'd0, o_negative, o_zero, o_writeback}, 8'd1);
    end
    // Back-to-back accept from DONE; B=07 is still cached.
    do_op("b2b",  3'b000, 8'h01, 8'h07, 1'b1, 8'h00, 3'b000, 8'h08, 1'b0, 1'b0, 1'b1);
    drain("b2b");

    // Reset in the middle of EXEC.
    i_valid = 1'b1; i_op = 3'b000; i_a = 8'h11; i_b = 8'h22;
    @(negedge clk);
    i_valid = 1'b0;
    chk("mid.load", {7'd0, o_bWr}, 8'd1);
    @(negedge clk);
    chk("mid.exec", {7'd0, o_oe}, 8'd1);
    rst = 1'b1;
    #1;
    chk("mid.ready", {7'd0, o_ready}, 8'd1);
    chk("mid.ctl", {3'd0, o_bWr, o_oe, o_aluOp, o_subShiftDir}, 8'd0);
    chk("mid.a", o_a, 8'h00);
    chk("mid.res", o_result, 8'h00);
    chk("mid.vld", {7'd0, o_resultValid}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid.novld", {7'd0, o_resultValid}, 8'd0);
    // Cache was cleared, so B=07 must be reloaded.
    do_op("post", 3'b000, 8'h02, 8'h07, 1'b0, 8'h07, 3'b000, 8'h09, 1'b0, 1'b0, 1'b1);
    drain("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
